// File: rtl/ks_pkg.sv
// Shared definitions for the Karplus-Strong voice bank.
//   ks_state_e    : sweep FSM states
//   KS_MIN_LEN    : shortest delay line the datapath will run
//   KS_DAMP_W     : width of the damping shift control
//   ks_clamp_len  : clamps a requested length into [KS_MIN_LEN, max_len]
package ks_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_CALC,
        ST_WR
    } ks_state_e;

    localparam int unsigned KS_MIN_LEN = 4;
    localparam int          KS_DAMP_W  = 4;

    function automatic int unsigned ks_clamp_len(input int unsigned len,
                                                 input int unsigned max_len);
        if (len < KS_MIN_LEN) return KS_MIN_LEN;
        if (len > max_len)    return max_len;
        return len;
    endfunction

endpackage

// File: rtl/ks_delay_ram.sv
// Simple dual-port sample RAM shared by all voices.
//   clk           : clock
//   we/waddr/wdata: synchronous write port
//   re/raddr      : read request; rdata valid the cycle after re and held
//                   until the next read
// Contents are not reset; the owner clears them explicitly.
module ks_delay_ram #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ks_voice_bank.sv
// Polyphonic Karplus-Strong string core. VOICES recirculating delay lines
// share one RAM and are swept through a single read/filter/write datapath
// once per sample_tick.
//   clk, reset_n  : clock, asynchronous active-low reset
//   sample_tick   : start of an audio sample period (sweeps all voices)
//   pluck         : per-voice excitation request (latched until serviced)
//   voice_len     : packed per-voice delay lengths, clamped to [4, DEPTH]
//   damp          : damping shift, 0 disables damping
//   dnoise        : excitation noise, sampled in CALC
//   out_valid/out_voice/out_sample : one strobe per voice visit with the
//                   oldest sample of that voice
//   busy          : RAM clear or sweep in progress
//   overrun       : sticky, a tick arrived mid-sweep and was dropped
module ks_voice_bank
    import ks_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    parameter  int VOICES = 4,
    parameter  int LEN_W  = $clog2(DEPTH) + 1,
    localparam int VW     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sample_tick,
    input  logic [VOICES-1:0]         pluck,
    input  logic [VOICES*LEN_W-1:0]   voice_len,
    input  logic [KS_DAMP_W-1:0]      damp,
    input  logic signed [DATA_W-1:0]  dnoise,
    output logic                      out_valid,
    output logic [VW-1:0]             out_voice,
    output logic signed [DATA_W-1:0]  out_sample,
    output logic                      busy,
    output logic                      overrun
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WORDS = VOICES * DEPTH;
    localparam int RA    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [VW-1:0] LAST_V = VW'(VOICES - 1);

    ks_state_e state, state_nxt;

    logic [VW-1:0]                 vi;
    logic [RA-1:0]                 clr_addr;
    logic [VOICES-1:0][LEN_W-1:0]  len_a;
    logic [VOICES-1:0][AW-1:0]     ptr;
    logic [VOICES-1:0][DATA_W-1:0] prev;
    logic [VOICES-1:0][LEN_W-1:0]  excite;
    logic [VOICES-1:0]             pend, pend_clr;

    // Per-visit registers, captured in RD / CALC and consumed in WR.
    logic [LEN_W-1:0]  len_cur, len_r, pe_inc;
    logic [AW-1:0]     ptr_cur, pe_r;
    logic [DATA_W-1:0] x_r, wval_r, rdata, y;
    logic              hit_r;

    logic              ram_we, ram_re;
    logic [RA-1:0]     ram_waddr, ram_raddr, v_base;
    logic [DATA_W-1:0] ram_wdata;

    logic signed [DATA_W:0] sum, avg, ydamp;

    assign len_a = voice_len;

    // Length is re-evaluated on each visit; a stale pointer beyond a
    // shrunken length restarts at 0 so the access stays inside the region.
    assign len_cur = LEN_W'(ks_clamp_len(32'(len_a[vi]), DEPTH));
    assign ptr_cur = (LEN_W'(ptr[vi]) >= len_cur) ? '0 : ptr[vi];
    assign pe_inc  = LEN_W'(pe_r) + LEN_W'(1);
    assign v_base  = RA'(vi) << AW;

    assign ram_re    = (state == ST_RD);
    assign ram_raddr = v_base | RA'(ptr_cur);
    assign ram_we    = (state == ST_CLEAR) || (state == ST_WR);
    assign ram_waddr = (state == ST_CLEAR) ? clr_addr : (v_base | RA'(pe_r));
    assign ram_wdata = (state == ST_CLEAR) ? '0 : wval_r;

    assign busy = (state != ST_IDLE);

    // Two-tap average with optional damping; 33-bit intermediate so the
    // sum of two full-scale samples cannot overflow.
    always_comb begin
        sum   = $signed({rdata[DATA_W-1], rdata}) +
                $signed({prev[vi][DATA_W-1], prev[vi]});
        avg   = sum >>> 1;
        ydamp = (damp == '0) ? avg : avg - (avg >>> damp);
        y     = ydamp[DATA_W-1:0];
    end

    always_comb begin
        pend_clr = '0;
        if (state == ST_WR && hit_r) pend_clr[vi] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_addr == RA'(WORDS - 1)) state_nxt = ST_IDLE;
            ST_IDLE:  if (sample_tick) state_nxt = ST_RD;
            ST_RD:    state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ST_CALC;
            ST_CALC:  state_nxt = ST_WR;
            ST_WR:    state_nxt = (vi == LAST_V) ? ST_IDLE : ST_RD;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            vi         <= '0;
            ptr        <= '0;
            prev       <= '0;
            excite     <= '0;
            pend       <= '0;
            len_r      <= '0;
            pe_r       <= '0;
            x_r        <= '0;
            wval_r     <= '0;
            hit_r      <= 1'b0;
            out_valid  <= 1'b0;
            out_voice  <= '0;
            out_sample <= '0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            // A new pluck always wins over the clear of a serviced one.
            pend      <= (pend & ~pend_clr) | pluck;

            if (sample_tick && state != ST_IDLE && state != ST_CLEAR)
                overrun <= 1'b1;

            case (state)
                ST_CLEAR: clr_addr <= clr_addr + RA'(1);
                ST_IDLE:  if (sample_tick) vi <= '0;
                ST_RD: begin
                    len_r <= len_cur;
                    pe_r  <= ptr_cur;
                end
                ST_CALC: begin
                    x_r        <= rdata;
                    hit_r      <= pend[vi];
                    wval_r     <= (excite[vi] != '0 || pend[vi]) ? dnoise : y;
                    out_valid  <= 1'b1;
                    out_voice  <= vi;
                    out_sample <= rdata;
                end
                ST_WR: begin
                    prev[vi] <= x_r;
                    ptr[vi]  <= (pe_inc == len_r) ? '0 : AW'(pe_inc);
                    if (hit_r)
                        excite[vi] <= len_r - LEN_W'(1);
                    else if (excite[vi] != '0)
                        excite[vi] <= excite[vi] - LEN_W'(1);
                    if (vi != LAST_V) vi <= vi + VW'(1);
                end
                default: ;
            endcase
        end
    end

    ks_delay_ram #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .ADDR_W (RA)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ks_voice_bank.sv
// Directed bench for ks_voice_bank (DEPTH=16, VOICES=4, LEN_W=5).
module tb_ks_voice_bank;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int NV    = 4;
    localparam int LW    = 5;

    logic                 clk         = 1'b0;
    logic                 reset_n     = 1'b1;
    logic                 sample_tick = 1'b0;
    logic [NV-1:0]        pluck       = '0;
    logic [NV*LW-1:0]     voice_len   = '0;
    logic [3:0]           damp        = '0;
    logic signed [DW-1:0] dnoise      = '0;
    logic                 out_valid;
    logic [1:0]           out_voice;
    logic signed [DW-1:0] out_sample;
    logic                 busy;
    logic                 overrun;

    int total = 0;
    int bad   = 0;

    logic signed [DW-1:0] got [NV];
    int got_k [NV];
    int n_valid;
    int busy_n;

    ks_voice_bank #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .VOICES (NV),
        .LEN_W  (LW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .pluck       (pluck),
        .voice_len   (voice_len),
        .damp        (damp),
        .dnoise      (dnoise),
        .out_valid   (out_valid),
        .out_voice   (out_voice),
        .out_sample  (out_sample),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic set_len(input int v, input int l);
        voice_len[v*LW +: LW] = LW'(l);
    endtask

    task automatic pluck_pulse(input logic [NV-1:0] m);
        @(negedge clk) pluck = m;
        @(negedge clk) pluck = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        sample_tick = 1'b0;
        pluck = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_timeout busy=%0b exp=0", busy);
        end
    endtask

    // One sample period: tick, then watch 19 cycles recording each voice's
    // output and the cycle offset (relative to the tick cycle) it appeared.
    task automatic do_tick();
        for (int v = 0; v < NV; v++) begin
            got[v]   = 'x;
            got_k[v] = -1;
        end
        n_valid = 0;
        busy_n  = 0;
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_n++;
            if (out_valid) begin
                got[out_voice]   = out_sample;
                got_k[out_voice] = k;
                n_valid++;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        total++; if (out_voice !== 2'd0) begin bad++; $display("FAIL rst_out_voice got=%0d exp=0", out_voice); end
        total++; if (out_sample !== 0) begin bad++; $display("FAIL rst_out_sample got=%0d exp=0", out_sample); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%0b exp=0", overrun); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%0b exp=1", busy); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            sample_tick = (n < 40) && n[0];
        end
        sample_tick = 1'b0;
        total++; if (n != NV*DEPTH) begin bad++; $display("FAIL clear_busy_cycles got=%0d exp=%0d", n, NV*DEPTH); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clear_tick_overrun got=%0b exp=0", overrun); end
        do_tick();
        total++; if (n_valid != NV) begin bad++; $display("FAIL sweep_valid_count got=%0d exp=%0d", n_valid, NV); end
        total++; if (busy_n != 4*NV) begin bad++; $display("FAIL sweep_busy_cycles got=%0d exp=%0d", busy_n, 4*NV); end
        for (int v = 0; v < NV; v++) begin
            total++; if (got[v] !== 0) begin bad++; $display("FAIL first_sweep_v%0d got=%0d exp=0", v, got[v]); end
            total++; if (got_k[v] != 4 + 4*v) begin bad++; $display("FAIL latency_v%0d got=%0d exp=%0d", v, got_k[v], 4 + 4*v); end
        end
    endtask

    task automatic test_excitation();
        int e;
        apply_reset();
        for (int v = 0; v < NV; v++) set_len(v, 8);
        damp = 4'd0;
        dnoise = 1000;
        pluck_pulse(4'b0001);
        for (int t = 1; t <= 24; t++) begin
            do_tick();
            e = (t <= 8) ? 0 : (t <= 16) ? 1000 : (t == 17) ? 500 : 1000;
            total++; if (got[0] !== e) begin bad++; $display("FAIL excite_t%0d got=%0d exp=%0d", t, got[0], e); end
        end
    endtask

    task automatic test_damping();
        int e;
        apply_reset();
        for (int v = 0; v < NV; v++) set_len(v, 4);
        damp = 4'd2;
        dnoise = 1024;
        pluck_pulse(4'b0001);
        for (int t = 1; t <= 13; t++) begin
            do_tick();
            e = (t <= 4) ? 0 : (t <= 8) ? 1024 : (t == 9) ? 384 : (t <= 12) ? 768 : 528;
            if (t >= 4) begin
                total++; if (got[0] !== e) begin bad++; $display("FAIL damp_t%0d got=%0d exp=%0d", t, got[0], e); end
            end
        end
        damp = 4'd0;
    endtask

    task automatic test_clamp_wrap();
        apply_reset();
        set_len(0, 2);
        set_len(1, 31);
        set_len(2, 4);
        set_len(3, 4);
        dnoise = 77;
        pluck_pulse(4'b0011);
        for (int t = 1; t <= 17; t++) begin
            do_tick();
            if (t == 4) begin total++; if (got[0] !== 0) begin bad++; $display("FAIL clamp_lo_t4 got=%0d exp=0", got[0]); end end
            if (t == 5) begin total++; if (got[0] !== 77) begin bad++; $display("FAIL clamp_lo_t5 got=%0d exp=77", got[0]); end end
            if (t == 9) begin total++; if (got[0] !== 38) begin bad++; $display("FAIL clamp_lo_avg_t9 got=%0d exp=38", got[0]); end end
            if (t == 16) begin total++; if (got[1] !== 0) begin bad++; $display("FAIL clamp_hi_t16 got=%0d exp=0", got[1]); end end
            if (t == 17) begin total++; if (got[1] !== 77) begin bad++; $display("FAIL clamp_hi_t17 got=%0d exp=77", got[1]); end end
        end
    endtask

    task automatic test_shrink();
        int e;
        apply_reset();
        for (int v = 0; v < NV; v++) set_len(v, 4);
        set_len(0, 8);
        pluck_pulse(4'b0001);
        for (int t = 1; t <= 12; t++) begin
            dnoise = 100 * t;
            if (t == 7) set_len(0, 4);
            do_tick();
            if (t >= 7) begin
                e = (t <= 10) ? 100 * (t - 6) : 100 * (t - 4);
                total++; if (got[0] !== e) begin bad++; $display("FAIL shrink_t%0d got=%0d exp=%0d", t, got[0], e); end
            end
            if (t == 11) begin
                for (int v = 1; v < NV; v++) begin
                    total++; if (got[v] !== 0) begin bad++; $display("FAIL shrink_other_v%0d got=%0d exp=0", v, got[v]); end
                end
            end
        end
    endtask

    task automatic test_overrun();
        int nv;
        apply_reset();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_initial got=%0b exp=0", overrun); end
        nv = 0;
        @(negedge clk) sample_tick = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            sample_tick = (k == 3);
            if (out_valid) nv++;
        end
        sample_tick = 1'b0;
        total++; if (nv != NV) begin bad++; $display("FAIL ovr_valid_count got=%0d exp=%0d", nv, NV); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
        do_tick();
        total++; if (n_valid != NV) begin bad++; $display("FAIL ovr_next_sweep got=%0d exp=%0d", n_valid, NV); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
        @(negedge clk) reset_n = 1'b0;
        #1;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_reset got=%0b exp=0", overrun); end
        apply_reset();
    endtask

    task automatic test_simul_pluck();
        int e;
        apply_reset();
        for (int v = 0; v < NV; v++) set_len(v, 4);
        damp = 4'd0;
        dnoise = 555;
        pluck_pulse(4'b0101);
        for (int t = 1; t <= 5; t++) do_tick();
        for (int v = 0; v < NV; v++) begin
            e = (v % 2 == 0) ? 555 : 0;
            total++; if (got[v] !== e) begin bad++; $display("FAIL simul_v%0d got=%0d exp=%0d", v, got[v], e); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_excitation();
        test_damping();
        test_clamp_wrap();
        test_shrink();
        test_overrun();
        test_simul_pluck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
